// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: multiply FSM encoding,
// the x0 register index and the legal multiply-latency range.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned MUL_CNT_W   = 4;
    localparam int unsigned MUL_LAT_MIN = 2;
    localparam int unsigned MUL_LAT_MAX = 15;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LAST = 2'd2
    } mul_state_e;

    function automatic bit mul_lat_ok(input int unsigned lat);
        return (lat >= MUL_LAT_MIN) && (lat <= MUL_LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard unit: register ids and hazard
// sources in, stall/flush controls and performance counters out.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);
    import hazard_stall_unit_pkg::*;

    logic [REG_W-1:0] RS1_D;
    logic [REG_W-1:0] RS2_D;
    logic [REG_W-1:0] RD_E;
    logic             RegWriteE;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             MulE;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output RS1_D, RS2_D, RD_E, RegWriteE, ResultSrcE0, PCSrcE, MulE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  RS1_D, RS2_D, RD_E, RegWriteE, ResultSrcE0, PCSrcE, MulE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: increments on each qualifying cycle, holds at all-ones.
module hazard_stall_unit_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage pipeline: load-use detection,
// taken-branch flushes and multi-cycle multiply occupancy of Execute.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_unit_if.slave   bus
);

    mul_state_e           state_q;
    mul_state_e           state_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q;
    logic [MUL_CNT_W-1:0] mul_cnt_d;
    logic                 mul_stall;
    logic                 lw_stall;
    logic                 stall_fd;

    assign lw_stall = bus.ResultSrcE0 & bus.RegWriteE & (bus.RD_E != REG_X0) &
                      ((bus.RD_E == bus.RS1_D) | (bus.RD_E == bus.RS2_D));

    // Multiply occupancy: stall MUL_LAT-1 cycles, then let it advance in LAST.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        mul_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.MulE) begin
                    mul_stall = 1'b1;
                    if (MUL_LAT > 2) begin
                        state_d   = BUSY;
                        mul_cnt_d = MUL_CNT_W'(MUL_LAT - 2);
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            BUSY: begin
                mul_stall = 1'b1;
                mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
                if (mul_cnt_q == MUL_CNT_W'(1)) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mul_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // A taken branch makes the Decode instruction wrong-path, so no load-use stall.
    assign stall_fd = (lw_stall & ~bus.PCSrcE) | mul_stall;

    assign bus.StallF = rst & stall_fd;
    assign bus.StallD = rst & stall_fd;
    assign bus.StallE = rst & mul_stall;
    assign bus.FlushD = rst & bus.PCSrcE;
    assign bus.FlushE = rst & (bus.PCSrcE | (lw_stall & ~mul_stall));
    assign bus.FlushM = rst & mul_stall;

    hazard_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_fd),
        .cnt_o (bus.stall_cycles)
    );

    hazard_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (bus.PCSrcE),
        .cnt_o (bus.flush_events)
    );

    a_mul_lat_legal: assert property (@(posedge clk) mul_lat_ok(MUL_LAT));

    // Execute cannot resolve a branch while it is holding a multiply.
    a_no_branch_in_mul: assert property (@(posedge clk) disable iff (!rst)
                                         !(bus.PCSrcE && mul_stall));

endmodule
